// File: rtl/cam_power_seq.sv
// cam_power_seq: power-up sequencer for image sensors (PWDN, RESETB, settle, SCCB init start, timeout retries).
module cam_power_seq #(
    parameter int PWDN_CYCLES    = 25000,
    parameter int RESET_CYCLES   = 50000,
    parameter int SETTLE_CYCLES  = 525000,
    parameter int PULSE_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int MAX_RETRIES    = 3,
    parameter int CNT_W          = 22,
    parameter int RETRY_W        = 2
) (
    input  logic               meg25,
    input  logic               rst,
    input  logic               init_done,
    input  logic               restart,
    output logic               cam_pwdn,
    output logic               cam_rst_oe,
    output logic               init_start,
    output logic               started,
    output logic               error,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);
    localparam logic [2:0] S_PWDN   = 3'd0;
    localparam logic [2:0] S_RESET  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_PULSE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_READY  = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;
    localparam logic [CNT_W-1:0] PWDN_LAST    = CNT_W'(PWDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    logic [2:0]         cur, nxt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retries, retries_nxt;
    logic               hold;

    always_comb begin
        nxt = cur;
        retries_nxt = retries;
        case (cur)
            S_PWDN:   nxt = cnt == PWDN_LAST ? S_RESET : S_PWDN;
            S_RESET:  nxt = cnt == RESET_LAST ? S_SETTLE : S_RESET;
            S_SETTLE: nxt = cnt == SETTLE_LAST ? S_PULSE : S_SETTLE;
            S_PULSE:  nxt = cnt == PULSE_LAST ? S_WAIT : S_PULSE;
            S_WAIT: begin
                // init_done takes priority over a coincident timeout
                if (init_done)
                    nxt = S_READY;
                else if (cnt == TIMEOUT_LAST && retries < RETRY_MAX) begin
                    nxt = S_PWDN;
                    retries_nxt = retries + 1'b1;
                end else if (cnt == TIMEOUT_LAST)
                    nxt = S_FAIL;
            end
            S_READY, S_FAIL: begin
                nxt = restart ? S_PWDN : cur;
                retries_nxt = restart ? '0 : retries;
            end
            default: nxt = S_PWDN;
        endcase
    end

    // terminal states freeze the counter so it never wraps while idle
    assign hold = cur == S_READY || cur == S_FAIL;

    // outputs are registered decodes of the state occupied during this cycle
    always_ff @(posedge meg25) begin
        if (rst) begin
            cur        <= S_PWDN;
            cnt        <= '0;
            retries    <= '0;
            cam_pwdn   <= 1'b1;
            cam_rst_oe <= 1'b1;
            init_start <= 1'b0;
            started    <= 1'b0;
            error      <= 1'b0;
            retry_cnt  <= '0;
            state      <= S_PWDN;
        end else begin
            cur        <= nxt;
            cnt        <= nxt != cur ? '0 : hold ? cnt : cnt + 1'b1;
            retries    <= retries_nxt;
            cam_pwdn   <= cur == S_PWDN || cur == S_FAIL || cur > S_FAIL;
            cam_rst_oe <= cur == S_PWDN || cur == S_RESET || cur >= S_FAIL;
            init_start <= cur == S_PULSE;
            started    <= cur == S_READY;
            error      <= cur == S_FAIL;
            retry_cnt  <= retries;
            state      <= cur;
        end
    end
endmodule
